dmem_storebuf: RTL and testbench
================================

# dmem_storebuf

Data-memory responder for the pipelined datapath's MEM-stage port. It accepts stores (`MemWrite_M`, `ALUResult_M`, `WriteData_M`) into a small in-order store buffer and drains them into a word-addressed RAM array. It returns `ReadData_M` combinationally, forwarding pending buffered stores. A priority external port (bench preload/dump, future loader) shares the array write port, so the buffer can back up; `mem_stall` flags a store that cannot be taken.

## Interface
- `MEM_WORDS`, 256: array depth in 32-bit words; power of 2.
- `SB_DEPTH`, 4: store-buffer entries; power of 2, ≥2.
- `AW`, log2(`MEM_WORDS`): word-index width (derived).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `MemWrite_M`  in  1  store request this cycle.
- `ALUResult_M`  in  32  byte address; word index = `ALUResult_M[AW+1:2]`; bits [1:0] and above AW+1 ignored.
- `WriteData_M`  in  32  store data.
- `ReadData_M`  out  32  combinational load data.
- `ext_we`  in  1  external array write; has priority over drain.
- `ext_addr`  in  AW  external word index.
- `ext_wdata`  in  32  external write data.
- `ext_rdata`  out  32  combinational `array[ext_addr]` (array only, no buffer forwarding).
- `sb_count`  out  log2(`SB_DEPTH`)+1  valid entries.
- `sb_full`  out  1  `sb_count == SB_DEPTH`.
- `sb_empty`  out  1  `sb_count == 0`.
- `mem_stall`  out  1  combinational: `MemWrite_M & sb_full & ext_we`.

## Operation
- Buffer: circular FIFO of {word index, data}; head/tail pointers wrap modulo `SB_DEPTH`.
- Drain: when `ext_we=0` and `sb_count>0`, the head entry is written to the array and popped at the edge.
- External write: when `ext_we=1`, `array[ext_addr] <= ext_wdata` and there is no drain that cycle.
- Accept: a store is pushed at the tail iff `MemWrite_M & (!sb_full | !ext_we)`. A full buffer with a drain in the same cycle still accepts.
- A stalled store (`mem_stall=1`) is dropped. The requester must hold it until accepted.
- Count update: push only → +1; drain only → −1; both → unchanged.
- Load: `ReadData_M` = data of the youngest valid entry whose index matches. An entry being drained this cycle still counts as valid. With no match, `ReadData_M = array[index]`. A store being pushed in the same cycle is not forwarded.
- Duplicate addresses are not coalesced. Entries drain in program order, so the array ends with the youngest value.
- Ordering: if an external write and a buffered store hit the same word, the store drains later and overwrites it.
- Reset (asynchronous, any time, including mid-drain or mid-push):
  - pointers and count clear; pending stores are discarded.
  - array contents are not reset.
  - Immediately after reset: `sb_count=0`, `sb_empty=1`, `sb_full=0`, `mem_stall=0`; `ReadData_M`/`ext_rdata` reflect the array.

## Timing
- Store accepted at edge N: visible on `ReadData_M` via forwarding from cycle N+1.
- Earliest array write: edge N+1 (if buffer was empty and `ext_we=0`); visible on `ext_rdata` from cycle N+2.
- Drain throughput: 1 entry/cycle while `ext_we=0`. Full to empty takes `SB_DEPTH` cycles.
- Flags are registered-state derived, so they change only at edges or on reset assertion. `mem_stall` and both read outputs are combinational.
- Load latency: 0 cycles. `ReadData_M` settles within the cycle for the datapath's MEM/WB latch.

## Test plan
- Reset/preload: assert reset → `sb_empty=1`, `sb_count=0`, `mem_stall=0`. Use `ext_we` to write `0xDEADBEEF` at index 5, then read `ALUResult_M=0x14` → `ReadData_M=0xDEADBEEF`.
- Single store: store `0x11111111` to `0x20` with `ext_we=0`:
  - count becomes 1 at edge N, 0 at edge N+1.
  - `ext_addr=8` → `ext_rdata=0x11111111` from cycle N+2.
- Fill and stall: hold `ext_we=1` (addr `0x3F`) and store to `0x40`, `0x44`, `0x48`, `0x4C` → `sb_full=1`.
  - A 5th store → `mem_stall=1`, count stays 4.
  - Release `ext_we` → the four entries drain in order over 4 cycles; then `sb_empty=1`.
- Forwarding: with `ext_we=1`, store `0xAAAA0000` then `0xBBBB0000` to `0x80`.
  - Read `0x80` → `0xBBBB0000`.
  - After the drain, `ext_rdata` at index `0x20` = `0xBBBB0000`.
- Full plus drain: `sb_count=4`, `ext_we=0`, store to `0x90` → `mem_stall=0`, accepted, count stays 4.
- Reset mid-operation: with 3 entries pending (including one store to `0x14` with data `0x5`), assert reset between edges.
  - Flags clear immediately.
  - Read `0x14` → `0xDEADBEEF` (old array value; the buffered store is lost).

Source files
------------

// File: rtl/dmem_storebuf.sv
`default_nettype none
// ============================================================================
// Module   : dmem_storebuf
// Purpose  : MEM-stage data-memory responder. Stores are queued in a small
//            in-order store buffer and drained one per cycle into a
//            word-addressed RAM array. Loads are answered combinationally,
//            with pending buffered stores forwarded (youngest match wins).
//            An external port (preload/dump/loader) has priority on the
//            array write port, so the buffer can back up and stall stores.
// Ports    : clk, reset         - clock, asynchronous active-high reset
//            MemWrite_M         - store request
//            ALUResult_M        - byte address (word index = [AW+1:2])
//            WriteData_M        - store data
//            ReadData_M         - combinational load data (forwarded)
//            ext_we/addr/wdata  - external array write (priority over drain)
//            ext_rdata          - combinational array[ext_addr], no forwarding
//            sb_count/full/empty- buffer occupancy status
//            mem_stall          - store cannot be taken this cycle
// Revision : 1.0 - initial release
// ============================================================================
module dmem_storebuf #(
    parameter int MEM_WORDS = 256,
    parameter int SB_DEPTH  = 4,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        MemWrite_M,
    input  logic [31:0]                 ALUResult_M,
    input  logic [31:0]                 WriteData_M,
    output logic [31:0]                 ReadData_M,
    input  logic                        ext_we,
    input  logic [AW-1:0]               ext_addr,
    input  logic [31:0]                 ext_wdata,
    output logic [31:0]                 ext_rdata,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_full,
    output logic                        sb_empty,
    output logic                        mem_stall
);

    localparam int c_PW = $clog2(SB_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(SB_DEPTH);

    logic [31:0]     r_mem     [MEM_WORDS];
    logic [AW-1:0]   r_sb_addr [SB_DEPTH];
    logic [31:0]     r_sb_data [SB_DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic [AW-1:0]   w_ld_idx;
    logic            w_push;
    logic            w_drain;
    logic            w_fwd_hit;
    logic [31:0]     w_fwd_data;
    logic [c_PW-1:0] w_slot;
    logic            w_unused;

    assign w_ld_idx = ALUResult_M[AW+1:2];
    // Byte-offset and out-of-range address bits are intentionally ignored.
    assign w_unused = ^{ALUResult_M[31:AW+2], ALUResult_M[1:0]};

    assign sb_count  = r_count;
    assign sb_full   = (r_count == c_DEPTH);
    assign sb_empty  = (r_count == '0);
    assign mem_stall = MemWrite_M & sb_full & ext_we;

    // A full buffer can still accept when the head drains in the same cycle;
    // the freed slot is the one the tail points at.
    assign w_push  = MemWrite_M & (~sb_full | ~ext_we);
    assign w_drain = ~ext_we & ~sb_empty;

    // Walk entries oldest to youngest so the last hit is the youngest store.
    // The head entry stays visible during its drain cycle because the array
    // write only lands at the edge.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_slot     = r_head;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_slot = r_head + c_PW'(k);
            if ((c_CW'(k) < r_count) && (r_sb_addr[w_slot] == w_ld_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_sb_data[w_slot];
            end
        end
    end

    assign ReadData_M = w_fwd_hit ? w_fwd_data : r_mem[w_ld_idx];
    assign ext_rdata  = r_mem[ext_addr];

    // Array contents survive reset; only the external port or a drain writes.
    always_ff @(posedge clk) begin
        if (ext_we) begin
            r_mem[ext_addr] <= ext_wdata;
        end else if (w_drain) begin
            r_mem[r_sb_addr[r_head]] <= r_sb_data[r_head];
        end
    end

    // Entry payload needs no reset: validity is carried by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_tail] <= w_ld_idx;
            r_sb_data[r_tail] <= WriteData_M;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + c_PW'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_storebuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_storebuf
// Purpose  : Self-checking bench for dmem_storebuf: directed vector table,
//            hand-written reset sequence, randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_storebuf;

    localparam int c_MEM_WORDS = 256;
    localparam int c_SB_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite_M = 1'b0;
    logic [31:0] ALUResult_M = '0;
    logic [31:0] WriteData_M = '0;
    logic [31:0] ReadData_M;
    logic        ext_we = 1'b0;
    logic [7:0]  ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [31:0] ext_rdata;
    logic [2:0]  sb_count;
    logic        sb_full;
    logic        sb_empty;
    logic        mem_stall;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [c_MEM_WORDS];

    typedef struct {
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        ew;
        logic [7:0]  ea;
        logic [31:0] ewd;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
        logic        stall;
        logic [31:0] rd;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    dmem_storebuf #(
        .MEM_WORDS(c_MEM_WORDS),
        .SB_DEPTH (c_SB_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite_M (MemWrite_M),
        .ALUResult_M(ALUResult_M),
        .WriteData_M(WriteData_M),
        .ReadData_M (ReadData_M),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .sb_count   (sb_count),
        .sb_full    (sb_full),
        .sb_empty   (sb_empty),
        .mem_stall  (mem_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pre(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic mw, input logic [31:0] alu,
                                input logic [31:0] wd, input logic ew,
                                input logic [7:0] ea, input logic [31:0] ewd,
                                input logic [2:0] cnt, input logic full,
                                input logic empty, input logic stall,
                                input logic [31:0] rd, input logic [31:0] erd);
        vec_t v;
        v.mw = mw; v.alu = alu; v.wd = wd; v.ew = ew; v.ea = ea; v.ewd = ewd;
        v.cnt = cnt; v.full = full; v.empty = empty; v.stall = stall;
        v.rd = rd; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] alu, input logic [31:0] wd,
                         input logic ew, input logic [7:0] ea, input logic [31:0] ewd);
        MemWrite_M  = mw;
        ALUResult_M = alu;
        WriteData_M = wd;
        ext_we      = ew;
        ext_addr    = ea;
        ext_wdata   = ewd;
    endtask

    // Reference model: FIFO of pending stores plus a plain array image.
    task automatic tick();
        bit full;
        bit push;
        bit drain;
        @(posedge clk);
        if (!reset) begin
            full  = (q.size() == c_SB_DEPTH);
            push  = MemWrite_M && !(full && ext_we);
            drain = !ext_we && (q.size() > 0);
            if (ext_we) begin
                mem_m[ext_addr] = ext_wdata;
            end else if (drain) begin
                mem_m[q[0].idx] = q[0].data;
                void'(q.pop_front());
            end
            if (push) q.push_back('{ALUResult_M[9:2], WriteData_M});
        end
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] exp_rd;
        bit          found;
        logic [7:0]  li;
        li     = ALUResult_M[9:2];
        exp_rd = mem_m[li];
        found  = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!found && q[i].idx == li) begin
                exp_rd = q[i].data;
                found  = 1'b1;
            end
        end
        chk({tag, "_cnt"},   32'(sb_count),  32'(q.size()));
        chk({tag, "_full"},  32'(sb_full),   32'(q.size() == c_SB_DEPTH));
        chk({tag, "_empty"}, 32'(sb_empty),  32'(q.size() == 0));
        chk({tag, "_stall"}, 32'(mem_stall), 32'(MemWrite_M && ext_we && q.size() == c_SB_DEPTH));
        chk({tag, "_rd"},    ReadData_M,     exp_rd);
        chk({tag, "_erd"},   ext_rdata,      mem_m[ext_addr]);
    endtask

    initial begin
        logic [7:0] ridx;
        bit         busy;

        // Directed table: outputs expected during the cycle, before its edge.
        // Reset/preload of index 5
        tbl.push_back(mk(0, 32'h14, 0, 1, 8'h05, 32'hDEADBEEF, 0,0,1,0, pre(5), pre(5)));
        tbl.push_back(mk(0, 32'h14, 0, 0, 8'h05, 0,            0,0,1,0, 32'hDEADBEEF, 32'hDEADBEEF));
        // Single store: not forwarded in its push cycle, forwarded next cycle
        tbl.push_back(mk(1, 32'h20, 32'h11111111, 0, 8'h08, 0, 0,0,1,0, pre(8), pre(8)));
        tbl.push_back(mk(0, 32'h20, 0, 0, 8'h08, 0,            1,0,0,0, 32'h11111111, pre(8)));
        tbl.push_back(mk(0, 32'h20, 0, 0, 8'h08, 0,            0,0,1,0, 32'h11111111, 32'h11111111));
        // Fill under external writes, then stall
        tbl.push_back(mk(1, 32'h40, 32'hC0DE0040, 1, 8'h3F, 32'h3F3F3F3F, 0,0,1,0, pre(16), pre(63)));
        tbl.push_back(mk(1, 32'h44, 32'hC0DE0044, 1, 8'h3F, 32'h3F3F3F3F, 1,0,0,0, pre(17), 32'h3F3F3F3F));
        tbl.push_back(mk(1, 32'h48, 32'hC0DE0048, 1, 8'h3F, 32'h3F3F3F3F, 2,0,0,0, pre(18), 32'h3F3F3F3F));
        tbl.push_back(mk(1, 32'h4C, 32'hC0DE004C, 1, 8'h3F, 32'h3F3F3F3F, 3,0,0,0, pre(19), 32'h3F3F3F3F));
        tbl.push_back(mk(1, 32'h50, 32'hC0DE0050, 1, 8'h3F, 32'h3F3F3F3F, 4,1,0,1, pre(20), 32'h3F3F3F3F));
        // Release: in-order drain, head still forwarded while draining
        tbl.push_back(mk(0, 32'h40, 0, 0, 8'h10, 0, 4,1,0,0, 32'hC0DE0040, pre(16)));
        tbl.push_back(mk(0, 32'h44, 0, 0, 8'h10, 0, 3,0,0,0, 32'hC0DE0044, 32'hC0DE0040));
        tbl.push_back(mk(0, 32'h48, 0, 0, 8'h11, 0, 2,0,0,0, 32'hC0DE0048, 32'hC0DE0044));
        tbl.push_back(mk(0, 32'h4C, 0, 0, 8'h12, 0, 1,0,0,0, 32'hC0DE004C, 32'hC0DE0048));
        tbl.push_back(mk(0, 32'h4C, 0, 0, 8'h13, 0, 0,0,1,0, 32'hC0DE004C, 32'hC0DE004C));
        // Forwarding of duplicate addresses: youngest wins
        tbl.push_back(mk(1, 32'h80, 32'hAAAA0000, 1, 8'h3E, 32'h3E3E3E3E, 0,0,1,0, pre(32), pre(62)));
        tbl.push_back(mk(1, 32'h80, 32'hBBBB0000, 1, 8'h3E, 32'h3E3E3E3E, 1,0,0,0, 32'hAAAA0000, 32'h3E3E3E3E));
        tbl.push_back(mk(0, 32'h80, 0,            1, 8'h3E, 32'h3E3E3E3E, 2,0,0,0, 32'hBBBB0000, 32'h3E3E3E3E));
        tbl.push_back(mk(0, 32'h80, 0, 0, 8'h20, 0, 2,0,0,0, 32'hBBBB0000, pre(32)));
        tbl.push_back(mk(0, 32'h80, 0, 0, 8'h20, 0, 1,0,0,0, 32'hBBBB0000, 32'hAAAA0000));
        tbl.push_back(mk(0, 32'h80, 0, 0, 8'h20, 0, 0,0,1,0, 32'hBBBB0000, 32'hBBBB0000));
        // Full plus drain: store accepted, count holds at 4
        tbl.push_back(mk(1, 32'hA0, 32'hD00000A0, 1, 8'h3D, 32'h3D3D3D3D, 0,0,1,0, pre(40), pre(61)));
        tbl.push_back(mk(1, 32'hA4, 32'hD00000A4, 1, 8'h3D, 32'h3D3D3D3D, 1,0,0,0, pre(41), 32'h3D3D3D3D));
        tbl.push_back(mk(1, 32'hA8, 32'hD00000A8, 1, 8'h3D, 32'h3D3D3D3D, 2,0,0,0, pre(42), 32'h3D3D3D3D));
        tbl.push_back(mk(1, 32'hAC, 32'hD00000AC, 1, 8'h3D, 32'h3D3D3D3D, 3,0,0,0, pre(43), 32'h3D3D3D3D));
        tbl.push_back(mk(1, 32'h90, 32'h90909090, 0, 8'h28, 0, 4,1,0,0, pre(36), pre(40)));
        tbl.push_back(mk(0, 32'h90, 0,            0, 8'h28, 0, 4,1,0,0, 32'h90909090, 32'hD00000A0));

        // Reset state
        drive(1, 32'h0, 32'h0, 0, 8'h0, 32'h0);
        #1 reset = 1'b1;
        q.delete();
        #1;
        chk("init_cnt",   32'(sb_count),  32'd0);
        chk("init_empty", 32'(sb_empty),  32'd1);
        chk("init_full",  32'(sb_full),   32'd0);
        chk("init_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Preload every word so the array has known contents
        for (int i = 0; i < c_MEM_WORDS; i++) begin
            drive(0, 32'h0, 32'h0, 1, 8'(i), pre(i));
            tick();
        end

        foreach (tbl[i]) begin
            drive(tbl[i].mw, tbl[i].alu, tbl[i].wd, tbl[i].ew, tbl[i].ea, tbl[i].ewd);
            #1;
            chk($sformatf("v%0d_cnt", i),   32'(sb_count),  32'(tbl[i].cnt));
            chk($sformatf("v%0d_full", i),  32'(sb_full),   32'(tbl[i].full));
            chk($sformatf("v%0d_empty", i), 32'(sb_empty),  32'(tbl[i].empty));
            chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(tbl[i].stall));
            chk($sformatf("v%0d_rd", i),    ReadData_M,     tbl[i].rd);
            chk($sformatf("v%0d_erd", i),   ext_rdata,      tbl[i].erd);
            tick();
        end

        // Drain what the table left behind
        for (int i = 0; i < c_SB_DEPTH; i++) begin
            drive(0, 32'h90, 32'h0, 0, 8'h24, 32'h0);
            #1;
            chk_model($sformatf("d%0d", i));
            tick();
        end
        #1;
        chk("drain_empty", 32'(sb_empty), 32'd1);

        // Reset mid-operation with three stores pending
        drive(1, 32'h14, 32'h5, 1, 8'h3C, 32'h3C3C3C3C); #1; chk_model("p0"); tick();
        drive(1, 32'h18, 32'h6, 1, 8'h3C, 32'h3C3C3C3C); #1; chk_model("p1"); tick();
        drive(1, 32'h1C, 32'h7, 1, 8'h3C, 32'h3C3C3C3C); #1; chk_model("p2"); tick();
        drive(1, 32'h14, 32'h0, 1, 8'h3C, 32'h3C3C3C3C);
        #1;
        chk("pre_rst_cnt", 32'(sb_count), 32'd3);
        chk("pre_rst_fwd", ReadData_M,    32'h5);
        #2;
        reset  = 1'b1;
        ext_we = 1'b0;
        q.delete();
        #1;
        chk("rst_cnt",   32'(sb_count),  32'd0);
        chk("rst_empty", 32'(sb_empty),  32'd1);
        chk("rst_full",  32'(sb_full),   32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_rd",    ReadData_M,     32'hDEADBEEF);
        chk("rst_erd",   ext_rdata,      32'h3C3C3C3C);
        tick();
        reset = 1'b0;
        drive(0, 32'h14, 32'h0, 0, 8'h05, 32'h0);
        #1;
        chk("post_rst_cnt", 32'(sb_count), 32'd0);
        chk("post_rst_erd", ext_rdata,     32'hDEADBEEF);
        tick();

        // Randomized traffic against the reference model
        busy = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) busy = ~busy;
            ridx = 8'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_FC03) | {22'b0, ridx, 2'b00},
                  $urandom,
                  busy ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 1),
                  8'($urandom_range(0, 15)),
                  $urandom);
            #1;
            chk_model($sformatf("r%0d", n));
            if ($urandom_range(0, 199) == 0) begin
                reset  = 1'b1;
                ext_we = 1'b0;
                q.delete();
                #1;
                chk_model($sformatf("r%0d_rst", n));
            end
            tick();
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
